datapath_histogram_acc: RTL
===========================

# datapath_histogram_acc

Parametrised, frame-based histogram accumulator for the pixel datapath. It maps each accepted 8-bit-class sample to one of `P_BINS` bins and keeps saturating per-bin counts in two ping-pong banks. On every start-of-frame it swaps banks and streams out the completed frame's histogram, one bin per beat, under downstream backpressure. It sits after the pixel source, in the slot of the single-sample bin mapper, and feeds the statistics/readout stage.

## Interface
- `P_DATA_W`, 8: sample width.
- `P_BINS`, 30: number of bins, 2..256.
- `P_CNT_W`, 16: per-bin counter and `data_out` width.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  `P_DATA_W`  sample.
- `valid_in`  in  1  sample valid.
- `sof_in`  in  1  the sample is the first of a new frame.
- `busy_out`  out  1  combinational; beat not accepted while high.
- `data_out`  out  `P_CNT_W`  bin count.
- `bin_out`  out  8  bin index of `data_out`.
- `valid_out`  out  1  output beat valid.
- `sof_out`  out  1  high with bin 0.
- `eof_out`  out  1  high with bin `P_BINS-1`.
- `busy_in`  in  1  downstream stall.

## Operation
- Accept: beat accepted when `valid_in && !busy_out`.
- `busy_out = sof_in && dump_active`. It is never high otherwise.
- Bin mapping: `bin = (data_in * P_BINS) >> P_DATA_W`, with an unsigned product of width `P_DATA_W+8`. The result is range 0..`P_BINS-1`. Example: `P_BINS`=30, data 255 -> 29; data 0 -> 0; data 128 -> 15.
- Stage 1 registers the bin, a valid flag and the target bank. Stage 2 increments `bank[tgt][bin]`.
  - Increment saturates at `2^P_CNT_W-1`.
  - The counters are a register array, so there is no read-modify-write hazard between back-to-back beats to the same bin.
- Banks: `acc_bank` (accumulating) and the other one (dump bank). After reset both banks are zero, `acc_bank`=0, `frame_seen`=0 and `dump_active`=0.
- Accepted sof beat:
  - `acc_bank` toggles. The sof sample itself is counted into the new bank.
  - If `frame_seen` is set, `dump_active` is set and the dump of the old bank begins.
  - `frame_seen` is then set.
  - The first sof after reset toggles the banks but starts no dump.
- Dump:
  - A bin pointer runs 0..`P_BINS-1`.
  - Each time the output register loads, it takes `bank[dump][ptr]`, `bin_out`=ptr, `sof_out`=(ptr==0) and `eof_out`=(ptr==`P_BINS-1`). In the same edge it clears that counter to 0.
  - After loading `P_BINS-1`, `dump_active` clears.
  - Every bin is therefore zero again before its bank becomes the accumulating bank.
- Output register:
  - Loads when `dump_active && (!valid_out || !busy_in)`.
  - `valid_out` clears when the register empties with nothing left to load.
  - While `valid_out && busy_in`, all outputs are held unchanged.
- Samples in the cycles around the swap:
  - A non-sof beat accepted before the sof goes to the old bank.
  - The dump's first read happens no earlier than one edge after that beat's increment.

## Timing
- Reset values: `data_out`=0, `bin_out`=0, `valid_out`=0, `sof_out`=0, `eof_out`=0. `busy_out` is 0 whenever `sof_in`=0.
- Accumulate latency: a sample accepted at edge E is visible in the counter at E+1.
- Dump latency: with the sof accepted at edge E, the first dump beat (bin 0) has `valid_out`=1 after edge E+2.
  - With no stall, there are `P_BINS` consecutive beats.
  - Every `busy_in` cycle adds one cycle.
- Sof during a dump: held off by `busy_out` until `dump_active` clears, i.e. until the edge that loads bin `P_BINS-1`. It is accepted from the following cycle.
- Non-sof samples are accepted every cycle, including during a dump and during a stall.
- Reset mid-dump: all outputs return to their reset values asynchronously. Both banks are cleared and `frame_seen` is cleared.
- `valid_in=0` cycles are ignored. `sof_in` without `valid_in` has no effect.

## Test plan
- Reset, frame A (sof + 9 more samples of value 0), then sof of frame B -> no dump after frame A's sof. After frame B's sof, 30 beats: bin 0 = 10, all others 0, `sof_out` on bin 0, `eof_out` on bin 29.
- One frame containing data 0, 8, 9, 128, 255, 255 -> counts are bin0=2 (data 0 and 8), bin1=1, bin15=1, bin29=2; all other bins 0.
- 70000 samples of the same value with `P_CNT_W`=16 -> that bin reads 65535, with no wrap to a small value.
- `busy_in` toggled high on every other cycle during a dump -> no beat lost or duplicated. While `busy_in` is high, all outputs hold their values from the previous cycle. The dump completes in 59 cycles.
- Next sof issued one cycle after the previous sof -> `busy_out`=1 until bin 29 loads. The held sof is then accepted. The second dump shows only samples from its own frame, proving the clear-on-dump.
- `i_rst_n` asserted at dump bin 12 -> `valid_out` drops immediately. After reset and two new frames, the counts contain no residue from before the reset.

Source files
------------

// File: rtl/datapath_histogram_acc.sv
// Frame histogram: maps samples to P_BINS bins, counts into ping-pong banks, dumps the finished frame on sof.
// Latency: sample visible in its counter one edge after acceptance; first dump beat valid two edges after the sof.
// Backpressure: busy_in stalls the output register (held stable); busy_out holds off a new sof while a dump runs.
module datapath_histogram_acc #(
  parameter int P_DATA_W = 8,
  parameter int P_BINS   = 30,
  parameter int P_CNT_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [P_DATA_W-1:0] data_in,
  input  logic                valid_in,
  input  logic                sof_in,
  output logic                busy_out,
  output logic [P_CNT_W-1:0]  data_out,
  output logic [7:0]          bin_out,
  output logic                valid_out,
  output logic                sof_out,
  output logic                eof_out,
  input  logic                busy_in
);

  localparam int                 PROD_W   = P_DATA_W + 8;
  localparam int                 IDX_W    = (P_BINS > 1) ? $clog2(P_BINS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(P_BINS - 1);
  localparam logic [P_CNT_W-1:0] CNT_MAX  = '1;

  // Bank control
  logic             acc_bank;     // bank currently accumulating
  logic             frame_seen;   // a frame has started since reset
  logic             dump_active;  // dump bank still has bins to read out
  logic             dump_arm;     // one-cycle gap so the last old-bank increment lands before the first read
  logic [IDX_W-1:0] dump_ptr;
  logic             dump_bank;

  // Stage 1: registered bin and target bank of the accepted sample
  logic             s1_vld;
  logic [IDX_W-1:0] s1_bin;
  logic             s1_tgt;

  logic [P_CNT_W-1:0] bank [2][P_BINS];

  logic              accept;
  logic              sof_acc;
  logic              load;
  logic [PROD_W-1:0] prod;
  logic [IDX_W-1:0]  bin_map;

  assign busy_out  = sof_in && dump_active;
  assign accept    = valid_in && !busy_out;
  assign sof_acc   = accept && sof_in;
  assign dump_bank = ~acc_bank;
  assign load      = dump_active && !dump_arm && (!valid_out || !busy_in);

  // bin = (data * P_BINS) >> P_DATA_W; the product never exceeds PROD_W bits
  assign prod    = PROD_W'(data_in) * PROD_W'(P_BINS);
  assign bin_map = IDX_W'(prod >> P_DATA_W);

  // Stage 1: capture bin and the bank it belongs to (a sof sample goes to the new bank)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld <= 1'b0;
      s1_bin <= '0;
      s1_tgt <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_bin <= bin_map;
        s1_tgt <= sof_in ? ~acc_bank : acc_bank;
      end
    end
  end

  // Bank swap on sof, dump start after the first frame, bin pointer walk during the dump
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_bank    <= 1'b0;
      frame_seen  <= 1'b0;
      dump_active <= 1'b0;
      dump_arm    <= 1'b0;
      dump_ptr    <= '0;
    end else begin
      dump_arm <= 1'b0;
      if (sof_acc) begin
        acc_bank   <= ~acc_bank;
        frame_seen <= 1'b1;
        if (frame_seen) begin
          dump_active <= 1'b1;
          dump_arm    <= 1'b1;
          dump_ptr    <= '0;
        end
      end
      if (load) begin
        if (dump_ptr == LAST_IDX) begin
          dump_active <= 1'b0;
          dump_ptr    <= '0;
        end else begin
          dump_ptr <= dump_ptr + IDX_W'(1);
        end
      end
    end
  end

  // Stage 2: saturating increment; the dumped bin is cleared as it is read out
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < P_BINS; i++) begin
          bank[b][i] <= '0;
        end
      end
    end else begin
      if (s1_vld && (bank[s1_tgt][s1_bin] != CNT_MAX)) begin
        bank[s1_tgt][s1_bin] <= bank[s1_tgt][s1_bin] + P_CNT_W'(1);
      end
      if (load) begin
        bank[dump_bank][dump_ptr] <= '0;
      end
    end
  end

  // Output register: load the next dump bin when empty or draining, hold while stalled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      bin_out   <= '0;
      sof_out   <= 1'b0;
      eof_out   <= 1'b0;
    end else if (load) begin
      valid_out <= 1'b1;
      data_out  <= bank[dump_bank][dump_ptr];
      bin_out   <= 8'(dump_ptr);
      sof_out   <= (dump_ptr == '0);
      eof_out   <= (dump_ptr == LAST_IDX);
    end else if (valid_out && !busy_in) begin
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      eof_out   <= 1'b0;
    end
  end

endmodule
